// File: rtl/jpegls_byte_packer.sv
// JPEG-LS output byte packer: packs MSB-first codewords into bytes with
// marker-avoidance bit stuffing, then pads and signals end of stream.
module jpegls_byte_packer #(
    parameter int dataOut_length      = 32,
    parameter int encodedlength_width = 6,
    parameter int acc_width           = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [dataOut_length-1:0]      dataOut,
    input  logic [encodedlength_width-1:0] dataSize,
    input  logic                           dataReady,
    input  logic                           endOfDataStream,
    output logic                           inReady,
    output logic [7:0]                     byteOut,
    output logic                           byteValid,
    output logic                           done,
    output logic                           overflow
);

    localparam int FW = $clog2(acc_width + 1);

    typedef enum logic [1:0] {RUN, FLUSH, PAD, DONE} state_t;

    state_t                 state, state_next;
    logic [acc_width-1:0]   acc, acc_next, acc_popped;
    logic [acc_width-1:0]   word_mask, word_ext;
    logic [FW-1:0]          fill, fill_next, fill_popped;
    logic [FW-1:0]          need, pop_bits, size_ext, shift_amt;
    logic                   last_ff, last_ff_next;
    logic                   pop_en, accept, drop;
    logic [7:0]             pop_byte, emit_byte;
    logic                   emit_valid, done_next;

    assign need     = last_ff ? FW'(7) : FW'(8);
    assign size_ext = FW'(dataSize);
    assign inReady  = (fill <= FW'(acc_width - dataOut_length));
    assign accept   = (state == RUN) && dataReady && inReady;
    assign drop     = (state == RUN) && dataReady && !inReady;

    // Bits beyond fill are kept zero, so a partial pop is already right-padded.
    always_comb begin
        pop_en      = (state != DONE) &&
                      ((fill >= need) || ((state == FLUSH) && (fill != '0)));
        pop_bits    = (fill >= need) ? need : fill;
        pop_byte    = last_ff ? {1'b0, acc[acc_width-1 -: 7]} : acc[acc_width-1 -: 8];
        acc_popped  = pop_en ? (acc << pop_bits) : acc;
        fill_popped = pop_en ? (fill - pop_bits) : fill;
        word_mask   = (acc_width'(1) << dataSize) - acc_width'(1);
        word_ext    = {{(acc_width-dataOut_length){1'b0}}, dataOut} & word_mask;
        shift_amt   = FW'(acc_width) - size_ext - fill_popped;
        acc_next    = acc_popped;
        fill_next   = fill_popped;
        if (accept) begin
            acc_next  = acc_popped | (word_ext << shift_amt);
            fill_next = fill_popped + size_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            acc      <= '0;
            fill     <= '0;
            last_ff  <= 1'b0;
            byteOut  <= 8'h00;
            byteValid <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            fill      <= fill_next;
            last_ff   <= last_ff_next;
            byteValid <= emit_valid;
            done      <= done_next;
            overflow  <= overflow | drop;
            if (emit_valid) begin
                byteOut <= emit_byte;
            end
        end
    end

    // An unstuffed flush goes straight to DONE so done follows the last byte by one cycle.
    always_comb begin
        state_next = state;
        case (state)
            RUN:   if (endOfDataStream) state_next = FLUSH;
            FLUSH: if (fill == '0) state_next = last_ff ? PAD : DONE;
            PAD:   if (!last_ff) state_next = DONE;
            DONE:  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        emit_valid   = pop_en;
        emit_byte    = pop_byte;
        last_ff_next = pop_en ? (pop_byte == 8'hFF) : last_ff;
        done_next    = (state_next == DONE);
        if ((state == PAD) && last_ff) begin
            emit_valid   = 1'b1;
            emit_byte    = 8'h00;
            last_ff_next = 1'b0;
        end
        if (state == DONE) begin
            last_ff_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_jpegls_byte_packer.sv
// Self-checking bench for jpegls_byte_packer: a bit-level reference model
// fills an expected-byte queue that a monitor drains as bytes appear.
module tb_jpegls_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataOut;
    logic [5:0]  dataSize;
    logic        dataReady;
    logic        endOfDataStream;
    logic        inReady;
    logic [7:0]  byteOut;
    logic        byteValid;
    logic        done;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    bit         bitQ[$];
    logic [7:0] expQ[$];
    bit         modelLastFF = 1'b0;

    int bytesSeen      = 0;
    int doneSeen       = 0;
    int cycleCount     = 0;
    int lastValidCycle = 0;
    bit streamHadBytes = 1'b0;
    int b0, d0;

    jpegls_byte_packer dut (
        .clk(clk),
        .reset(reset),
        .dataOut(dataOut),
        .dataSize(dataSize),
        .dataReady(dataReady),
        .endOfDataStream(endOfDataStream),
        .inReady(inReady),
        .byteOut(byteOut),
        .byteValid(byteValid),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void modelPush(input logic [31:0] data, input int size);
        for (int i = size - 1; i >= 0; i--) bitQ.push_back(data[i]);
    endfunction

    function automatic void modelExtract();
        logic [7:0] b;
        int need;
        forever begin
            need = modelLastFF ? 7 : 8;
            if (bitQ.size() < need) break;
            b = 8'h00;
            for (int i = 0; i < need; i++) b = {b[6:0], bitQ.pop_front()};
            expQ.push_back(b);
            modelLastFF = (b == 8'hFF);
        end
    endfunction

    function automatic void modelFlush();
        logic [7:0] b;
        int need, r;
        need = modelLastFF ? 7 : 8;
        r    = bitQ.size();
        if (r > 0) begin
            b = 8'h00;
            for (int i = 0; i < need; i++) b = {b[6:0], (i < r) ? bitQ.pop_front() : 1'b0};
            expQ.push_back(b);
            modelLastFF = (b == 8'hFF);
        end
        if (modelLastFF) expQ.push_back(8'h00);
        modelLastFF = 1'b0;
    endfunction

    // Drives one codeword for one cycle, starting and ending on a falling edge.
    task automatic applyStimulus(input logic [31:0] data, input int size,
                                 input bit eos, input bit expAccept);
        dataOut         = data;
        dataSize        = 6'(size);
        dataReady       = 1'b1;
        endOfDataStream = eos;
        #1 checkOutput("inReady", 32'(inReady), 32'(expAccept));
        if (expAccept) begin
            modelPush(data, size);
            modelExtract();
        end
        if (eos) modelFlush();
        @(negedge clk);
        dataReady       = 1'b0;
        endOfDataStream = 1'b0;
    endtask

    task automatic idle(input int n);
        dataReady       = 1'b0;
        endOfDataStream = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard side: every valid byte must match the oldest expected byte.
    always @(negedge clk) begin
        cycleCount++;
        if (reset && byteValid) begin
            bytesSeen++;
            lastValidCycle = cycleCount;
            streamHadBytes = 1'b1;
            checkOutput("expPending", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) checkOutput("byteOut", 32'(byteOut), 32'(expQ.pop_front()));
        end
        if (reset && done) begin
            doneSeen++;
            checkOutput("doneNoByte", 32'(byteValid), 32'd0);
            if (streamHadBytes) checkOutput("doneLatency", 32'(cycleCount - lastValidCycle), 32'd1);
            checkOutput("doneQueueDrained", 32'(expQ.size()), 32'd0);
            streamHadBytes = 1'b0;
        end
    end

    initial begin
        reset = 1'b0;
        dataOut = '0;
        dataSize = '0;
        dataReady = 1'b0;
        endOfDataStream = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstByteOut", 32'(byteOut), 32'h00);
        checkOutput("rstByteValid", 32'(byteValid), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstOverflow", 32'(overflow), 32'd0);
        checkOutput("rstInReady", 32'(inReady), 32'd1);
        reset = 1'b1;

        b0 = bytesSeen;
        idle(10);
        checkOutput("idleBytes", 32'(bytesSeen - b0), 32'd0);

        b0 = bytesSeen;
        applyStimulus(32'h05, 3, 1'b0, 1'b1);
        applyStimulus(32'h1F, 5, 1'b0, 1'b1);
        idle(5);
        checkOutput("packBytes", 32'(bytesSeen - b0), 32'd1);

        b0 = bytesSeen;
        applyStimulus(32'hFF, 8, 1'b0, 1'b1);
        applyStimulus(32'h7F, 7, 1'b0, 1'b1);
        applyStimulus(32'hAA, 8, 1'b0, 1'b1);
        idle(6);
        checkOutput("stuffBytes", 32'(bytesSeen - b0), 32'd3);

        b0 = bytesSeen; d0 = doneSeen;
        applyStimulus(32'h1, 1, 1'b1, 1'b1);
        idle(6);
        checkOutput("flushBytes", 32'(bytesSeen - b0), 32'd1);
        checkOutput("flushDone", 32'(doneSeen - d0), 32'd1);

        b0 = bytesSeen; d0 = doneSeen;
        applyStimulus(32'hFF, 8, 1'b1, 1'b1);
        idle(8);
        checkOutput("padBytes", 32'(bytesSeen - b0), 32'd2);
        checkOutput("padDone", 32'(doneSeen - d0), 32'd1);

        b0 = bytesSeen;
        applyStimulus(32'h0, 0, 1'b1, 1'b1);
        checkOutput("emptyDoneEarly", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("emptyDone", 32'(done), 32'd1);
        idle(4);
        checkOutput("emptyBytes", 32'(bytesSeen - b0), 32'd0);

        b0 = bytesSeen;
        applyStimulus(32'h12345678, 32, 1'b0, 1'b1);
        applyStimulus(32'h9ABCDEF0, 32, 1'b0, 1'b1);
        applyStimulus(32'hDEADBEEF, 32, 1'b0, 1'b0);
        checkOutput("overflowSet", 32'(overflow), 32'd1);
        idle(12);
        checkOutput("overflowSticky", 32'(overflow), 32'd1);
        checkOutput("bpBytes", 32'(bytesSeen - b0), 32'd8);

        // Mixed random stream, paced so the accumulator never fills.
        b0 = bytesSeen; d0 = doneSeen;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
                          int'($urandom_range(0, 32)), (i == 29), 1'b1);
            idle(4);
        end
        idle(10);
        checkOutput("randDone", 32'(doneSeen - d0), 32'd1);

        applyStimulus(32'hABCDE, 20, 1'b1, 1'b1);
        reset = 1'b0;
        bitQ.delete();
        expQ.delete();
        modelLastFF = 1'b0;
        streamHadBytes = 1'b0;
        #1;
        checkOutput("midRstByteOut", 32'(byteOut), 32'h00);
        checkOutput("midRstByteValid", 32'(byteValid), 32'd0);
        checkOutput("midRstOverflow", 32'(overflow), 32'd0);
        checkOutput("midRstInReady", 32'(inReady), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        b0 = bytesSeen;
        applyStimulus(32'hA5, 8, 1'b0, 1'b1);
        idle(5);
        checkOutput("postRstBytes", 32'(bytesSeen - b0), 32'd1);
        checkOutput("finalQueueEmpty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
